// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide datapath blocks.
// State encodings and default operand widths for the divider and the multiplier.
package mips_pkg;

   localparam int N_DIV = 16;
   localparam int N_MUL = N_DIV;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOOP = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/divisor_passo.sv
// One restoring-division step.
// Shifts the next dividend bit into the partial remainder and conditionally subtracts the divisor.
module divisor_passo
   import mips_pkg::*;
#(
   parameter int N = N_DIV
) (
   input  logic [N:0]   r,
   input  logic         q_msb,
   input  logic [N-1:0] d,
   output logic [N:0]   r_next,
   output logic         q_bit
);

   logic [N:0] r_sh;
   logic [N:0] trial;
   logic       ge;

   always_comb begin
      r_sh = {r[N-1:0], q_msb};
      // A set r[N] means the true shifted value exceeds 2^(N+1) > d, so the trial must succeed.
      ge = r[N] | (r_sh >= {1'b0, d});
      trial = r_sh - {1'b0, d};
      q_bit = ge;
      r_next = ge ? trial : r_sh;
   end

endmodule

// File: rtl/divisor.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Handshake: St is sampled only while Idle=1; Done pulses for one cycle when results are valid.
module divisor
   import mips_pkg::*;
#(
   parameter int N = N_DIV
) (
   input  logic           Clk,
   input  logic           Rst,
   input  logic           St,
   input  logic [2*N-1:0] Dividendo,
   input  logic [N-1:0]   Divisor,
   output logic [N-1:0]   Quociente,
   output logic [N-1:0]   Resto,
   output logic           Idle,
   output logic           Done,
   output logic           Ovf
);

   localparam int CW = $clog2(N) + 1;

   logic [1:0]    state;
   logic [1:0]    state_next;
   logic [N:0]    r;
   logic [N-1:0]  q;
   logic [N-1:0]  d;
   logic [CW-1:0] cnt;
   logic [N:0]    r_next;
   logic          q_bit;
   logic          ovf_start;
   logic          last_iter;

   assign ovf_start = (Divisor == '0) || (Dividendo[2*N-1:N] >= Divisor);
   assign last_iter = (cnt == CW'(N - 1));

   divisor_passo #(.N(N)) u_passo (
      .r      (r),
      .q_msb  (q[N-1]),
      .d      (d),
      .r_next (r_next),
      .q_bit  (q_bit)
   );

   always_ff @(posedge Clk) begin
      if (Rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (St) state_next = ovf_start ? S_DONE : S_LOOP;
         S_LOOP:  if (last_iter) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      Idle = (state == S_IDLE);
      Done = (state == S_DONE);
   end

   // The upper dividend half is preloaded into R; only the lower half shifts through Q.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         Quociente <= '0;
         Resto     <= '0;
         Ovf       <= 1'b0;
         r         <= '0;
         q         <= '0;
         d         <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (St) begin
                  if (ovf_start) begin
                     Quociente <= '1;
                     Resto     <= '0;
                     Ovf       <= 1'b1;
                  end else begin
                     r   <= {1'b0, Dividendo[2*N-1:N]};
                     q   <= Dividendo[N-1:0];
                     d   <= Divisor;
                     cnt <= '0;
                     Ovf <= 1'b0;
                  end
               end
            end
            S_LOOP: begin
               r   <= r_next;
               q   <= {q[N-2:0], q_bit};
               cnt <= cnt + CW'(1);
               if (last_iter) begin
                  Quociente <= {q[N-2:0], q_bit};
                  Resto     <= r_next[N-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_divisor.sv
// Directed testbench for the divisor block with hand-computed expected results.
module tb_divisor;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic        St = 1'b0;
   logic [31:0] Dividendo = '0;
   logic [15:0] Divisor = '0;
   logic [15:0] Quociente;
   logic [15:0] Resto;
   logic        Idle;
   logic        Done;
   logic        Ovf;

   int total = 0;
   int bad = 0;

   divisor dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .St        (St),
      .Dividendo (Dividendo),
      .Divisor   (Divisor),
      .Quociente (Quociente),
      .Resto     (Resto),
      .Idle      (Idle),
      .Done      (Done),
      .Ovf       (Ovf)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulse St for one start edge, then count edges after E0 until Done and the Idle-low cycles.
   task automatic run_op(input string tag, input logic [31:0] dvd, input logic [15:0] dvs,
                         output int lat, output int idle_low);
      @(negedge Clk);
      Dividendo = dvd;
      Divisor   = dvs;
      St        = 1'b1;
      @(posedge Clk);
      #1;
      St = 1'b0;
      lat = 0;
      idle_low = 0;
      while (Done !== 1'b1 && lat < 100) begin
         if (Idle === 1'b0) idle_low++;
         @(posedge Clk);
         #1;
         lat++;
      end
      if (Idle === 1'b0) idle_low++;
      if (lat >= 100) check({tag, "_timeout"}, 32'(lat), 32'd0);
   endtask

   task automatic after_done(input string tag);
      @(posedge Clk);
      #1;
      check({tag, "_done_pulse"}, 32'(Done), 32'd0);
      check({tag, "_idle_back"}, 32'(Idle), 32'd1);
   endtask

   initial begin
      int lat;
      int idle_low;
      int n_done;
      int first_done;
      int second_done;

      Rst = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      Rst = 1'b0;
      check("rst_idle", 32'(Idle), 32'd1);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_quoc", 32'(Quociente), 32'd0);
      check("rst_resto", 32'(Resto), 32'd0);
      check("rst_ovf", 32'(Ovf), 32'd0);

      run_op("a", 32'd4000000, 16'd2000, lat, idle_low);
      check("a_latency", 32'(lat), 32'd16);
      check("a_quoc", 32'(Quociente), 32'd2000);
      check("a_resto", 32'(Resto), 32'd0);
      check("a_ovf", 32'(Ovf), 32'd0);
      after_done("a");

      run_op("b", 32'd100, 16'd7, lat, idle_low);
      check("b_quoc", 32'(Quociente), 32'd14);
      check("b_resto", 32'(Resto), 32'd2);
      after_done("b");
      check("b_idle_low", 32'(idle_low), 32'd17);

      run_op("max", 32'hFFFE_FFFF, 16'hFFFF, lat, idle_low);
      check("max_quoc", 32'(Quociente), 32'h0000_FFFF);
      check("max_resto", 32'(Resto), 32'h0000_FFFE);
      check("max_ovf", 32'(Ovf), 32'd0);
      after_done("max");

      run_op("c", 32'd1000, 16'd3, lat, idle_low);
      check("c_quoc", 32'(Quociente), 32'd333);
      check("c_resto", 32'(Resto), 32'd1);
      after_done("c");

      run_op("ovf0", 32'd12345, 16'd0, lat, idle_low);
      check("ovf0_latency", 32'(lat), 32'd0);
      check("ovf0_ovf", 32'(Ovf), 32'd1);
      check("ovf0_quoc", 32'(Quociente), 32'h0000_FFFF);
      check("ovf0_resto", 32'(Resto), 32'd0);
      after_done("ovf0");

      run_op("ovf1", 32'h0001_0000, 16'd1, lat, idle_low);
      check("ovf1_latency", 32'(lat), 32'd0);
      check("ovf1_ovf", 32'(Ovf), 32'd1);
      check("ovf1_quoc", 32'(Quociente), 32'h0000_FFFF);
      after_done("ovf1");

      // Operands and St disturbed during the loop must not affect the result.
      @(negedge Clk);
      Dividendo = 32'd100;
      Divisor   = 16'd7;
      St        = 1'b1;
      @(posedge Clk);
      #1;
      St = 1'b0;
      Dividendo = 32'h0000_0040;
      Divisor   = 16'd9;
      lat = 0;
      while (Done !== 1'b1 && lat < 100) begin
         @(negedge Clk);
         St = ~St;
         Dividendo = Dividendo + 32'd3;
         Divisor   = Divisor + 16'd1;
         @(posedge Clk);
         #1;
         lat++;
      end
      St = 1'b0;
      check("dist_latency", 32'(lat), 32'd16);
      check("dist_quoc", 32'(Quociente), 32'd14);
      check("dist_resto", 32'(Resto), 32'd2);
      check("dist_ovf", 32'(Ovf), 32'd0);
      after_done("dist");

      // Reset during iteration 8 discards the operation.
      @(negedge Clk);
      Dividendo = 32'd4000000;
      Divisor   = 16'd2000;
      St        = 1'b1;
      @(posedge Clk);
      #1;
      St = 1'b0;
      repeat (7) @(posedge Clk);
      @(negedge Clk);
      Rst = 1'b1;
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      check("mrst_idle", 32'(Idle), 32'd1);
      check("mrst_done", 32'(Done), 32'd0);
      check("mrst_quoc", 32'(Quociente), 32'd0);
      check("mrst_resto", 32'(Resto), 32'd0);
      check("mrst_ovf", 32'(Ovf), 32'd0);
      n_done = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge Clk);
         #1;
         if (Done === 1'b1) n_done++;
      end
      check("mrst_no_done", 32'(n_done), 32'd0);

      run_op("post", 32'd100, 16'd7, lat, idle_low);
      check("post_latency", 32'(lat), 32'd16);
      check("post_quoc", 32'(Quociente), 32'd14);
      check("post_resto", 32'(Resto), 32'd2);
      after_done("post");

      // St held high: back-to-back operations with Done pulses 18 cycles apart.
      @(negedge Clk);
      Dividendo = 32'd100;
      Divisor   = 16'd7;
      St        = 1'b1;
      n_done = 0;
      first_done = -1;
      second_done = -1;
      for (int e = 0; e < 45; e++) begin
         @(posedge Clk);
         #1;
         if (Done === 1'b1) begin
            if (n_done == 0) first_done = e;
            if (n_done == 1) second_done = e;
            n_done++;
         end
      end
      @(negedge Clk);
      St = 1'b0;
      check("b2b_count", 32'(n_done), 32'd2);
      check("b2b_first", 32'(first_done), 32'd16);
      check("b2b_spacing", 32'(second_done - first_done), 32'd18);
      check("b2b_quoc", 32'(Quociente), 32'd14);
      check("b2b_resto", 32'(Resto), 32'd2);
      lat = 0;
      while (Idle !== 1'b1 && lat < 40) begin
         @(posedge Clk);
         #1;
         lat++;
      end
      check("b2b_idle", 32'(Idle), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
